// File: rtl/mcc_pkg.sv
// Shared constants for the multi-channel counter engine.
// Latency: n/a (constants only).
// Backpressure: n/a.
package mcc_pkg;

  // Per-channel FSM encoding, kept as plain 2-bit constants so existing
  // register-file decode and debug scripts can keep using raw values.
  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_IRQ_START = 2'd1;
  localparam logic [1:0] ST_CALC      = 2'd2;
  localparam logic [1:0] ST_IRQ_DONE  = 2'd3;

  // Channel mode, latched at start.
  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_RELOAD  = 1'b1;

endpackage

// File: rtl/multi_channel_counter_ctrl_if.sv
// Control/status bundle between the counter register file and the engine.
// Latency: n/a (wires only).
// Backpressure: none; start/ack are the only handshakes, sampled per FSM state.
interface multi_channel_counter_ctrl_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32
);
  logic [NUM_CH-1:0]       start;
  logic [NUM_CH-1:0]       ack;
  logic [NUM_CH-1:0]       abort;
  logic [NUM_CH-1:0]       mode;
  logic [NUM_CH*CNT_W-1:0] limit;
  logic [NUM_CH-1:0]       irq_en;
  logic [NUM_CH*CNT_W-1:0] count;
  logic [NUM_CH-1:0]       busy;
  logic [NUM_CH-1:0]       irq_start;
  logic [NUM_CH-1:0]       irq_done;
  logic                    irq;

  // Register-file side: issues requests, observes status.
  modport master (
    output start, ack, abort, mode, limit, irq_en,
    input  count, busy, irq_start, irq_done, irq
  );

  // Counter engine side.
  modport slave (
    input  start, ack, abort, mode, limit, irq_en,
    output count, busy, irq_start, irq_done, irq
  );
endinterface

// File: rtl/multi_channel_counter_ctrl_counter_channel.sv
// One counter channel: start/ack FSM plus its own counter, limit and mode.
// Latency: IRQ_START one cycle after start; CALC lasts lim_q+1 cycles.
// Backpressure: waits indefinitely in IRQ_START/IRQ_DONE until ack.
module counter_channel
  import mcc_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             ack_i,
  input  logic             abort_i,
  input  logic             mode_i,
  input  logic [CNT_W-1:0] limit_i,
  output logic [CNT_W-1:0] count_o,
  output logic             busy_o,
  output logic             irq_start_o,
  output logic             irq_done_o
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] lim_q, lim_d;
  logic             mode_q, mode_d;

  // Next-state and datapath: abort dominates, otherwise per-state handshake.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    lim_d   = lim_q;
    mode_d  = mode_q;
    if (abort_i) begin
      state_d = ST_IDLE;
      count_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // Count is left alone here so software can read the final value.
          if (start_i) begin
            state_d = ST_IRQ_START;
            lim_d   = limit_i;
            mode_d  = mode_i;
            count_d = '0;
          end
        end
        ST_IRQ_START: begin
          if (ack_i) state_d = ST_CALC;
        end
        ST_CALC: begin
          // Compare before incrementing so count never passes lim_q,
          // which also makes an all-ones limit safe from wrapping.
          if (count_q == lim_q) state_d = ST_IRQ_DONE;
          else                  count_d = count_q + CNT_ONE;
        end
        ST_IRQ_DONE: begin
          if (ack_i) begin
            if (mode_q == MODE_RELOAD) begin
              // Reload restarts counting directly with the latched limit.
              state_d = ST_CALC;
              count_d = '0;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      lim_q   <= '0;
      mode_q  <= MODE_ONESHOT;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      lim_q   <= lim_d;
      mode_q  <= mode_d;
    end
  end

  assign count_o     = count_q;
  assign busy_o      = (state_q != ST_IDLE);
  assign irq_start_o = (state_q == ST_IRQ_START);
  assign irq_done_o  = (state_q == ST_IRQ_DONE);

endmodule

// File: rtl/multi_channel_counter_ctrl.sv
// N independent counter channels with a maskable aggregate interrupt.
// Latency: per channel, see counter_channel; irq is a decode of channel state.
// Backpressure: none between channels; each waits only on its own ack.
module multi_channel_counter_ctrl
  import mcc_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  multi_channel_counter_ctrl_if.slave bus
);

  logic [NUM_CH*CNT_W-1:0] count_w;
  logic [NUM_CH-1:0]       busy_w;
  logic [NUM_CH-1:0]       irq_start_w;
  logic [NUM_CH-1:0]       irq_done_w;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    counter_channel #(
      .CNT_W (CNT_W)
    ) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_i     (bus.start[i]),
      .ack_i       (bus.ack[i]),
      .abort_i     (bus.abort[i]),
      .mode_i      (bus.mode[i]),
      .limit_i     (bus.limit[i*CNT_W +: CNT_W]),
      .count_o     (count_w[i*CNT_W +: CNT_W]),
      .busy_o      (busy_w[i]),
      .irq_start_o (irq_start_w[i]),
      .irq_done_o  (irq_done_w[i])
    );
  end

  assign bus.count     = count_w;
  assign bus.busy      = busy_w;
  assign bus.irq_start = irq_start_w;
  assign bus.irq_done  = irq_done_w;
  // Aggregate line to the PS; depends only on registered state and the mask.
  assign bus.irq       = |((irq_start_w | irq_done_w) & bus.irq_en);

endmodule

// File: doc/multi_channel_counter_ctrl.md
Name: multi_channel_counter_ctrl

Overview:
- Parametrised N-channel counter engine. Each channel has its own start/ack interrupt handshake, a programmable terminal count, and either one-shot or auto-reload mode.
- Each channel embeds its own counter datapath, so the block provides counting, not only control.
- Sits behind the AXI counter IP register file.
- Drives per-channel interrupt status plus one aggregated, maskable interrupt line to the PS.

Parameters:
- NUM_CH, 4, number of independent counter channels (1..16).
- CNT_W, 32, counter and limit width in bits (2..32).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  NUM_CH  per-channel start request; sampled in IDLE only.
- ack  in  NUM_CH  per-channel interrupt acknowledge; sampled in IRQ_START/IRQ_DONE only.
- abort  in  NUM_CH  per-channel abort; forces the channel to IDLE.
- mode  in  NUM_CH  0 = one-shot, 1 = auto-reload; latched at start.
- limit  in  NUM_CH*CNT_W  terminal count per channel, channel i at bits [i*CNT_W +: CNT_W]; latched at start.
- irq_en  in  NUM_CH  per-channel interrupt mask for the aggregate irq.
- count  out  NUM_CH*CNT_W  live counter value per channel.
- busy  out  NUM_CH  channel is not in IDLE.
- irq_start  out  NUM_CH  level; channel is in IRQ_START.
- irq_done  out  NUM_CH  level; channel is in IRQ_DONE.
- irq  out  1  OR over i of ((irq_start[i] | irq_done[i]) & irq_en[i]).

Behaviour:
- Reset (async, rst_n low): all channels go to IDLE; count=0, lim_q=0, mode_q=0; busy, irq_start, irq_done and irq are all 0.
- Channels are fully independent and share no arbitration. All outputs are registered state or combinational decodes of state; no output depends combinationally on start or ack.
- Per-channel FSM states: IDLE, IRQ_START, CALC, IRQ_DONE.
  - IDLE: count holds its last value, so software can read the final count.
    - start=1 -> IRQ_START; in the same edge lim_q<=limit, mode_q<=mode, count<=0.
  - IRQ_START: irq_start=1.
    - ack=1 -> CALC; count stays 0.
  - CALC: busy=1.
    - If count==lim_q -> IRQ_DONE and count holds.
    - Otherwise count<=count+1.
    - CALC therefore lasts lim_q+1 cycles and the final count is lim_q.
    - lim_q=0 gives exactly one CALC cycle.
  - IRQ_DONE: irq_done=1; count holds.
    - ack=1 with mode_q=0 -> IDLE.
    - ack=1 with mode_q=1 -> CALC with count<=0. IRQ_START is skipped and lim_q is not reloaded.
- Abort has top priority in every state: next state IDLE, count<=0. Abort in IDLE clears count. Abort together with start in IDLE stays in IDLE with count 0.
- ack outside IRQ_START/IRQ_DONE is ignored. start outside IDLE is ignored.
- Changes to limit or mode while busy have no effect until the next start.
- Counter never wraps: count<=lim_q<=2^CNT_W-1, and no increment past lim_q occurs. limit all-ones is legal.
- ack held high continuously is legal: every IRQ state lasts exactly 1 cycle.

Decomposition:
- Shared package mcc_pkg holds:
  - state encoding constants ST_IDLE=0, ST_IRQ_START=1, ST_CALC=2, ST_IRQ_DONE=3, 2-bit;
  - MODE_ONESHOT=0, MODE_RELOAD=1.
- Sub-module counter_channel holds one FSM plus its CNT_W counter, lim_q and mode_q.
- The top instantiates counter_channel NUM_CH times in a generate loop, slices the limit and count buses, and forms irq.

Test Plan:
- One-shot, ch0, limit=5: start pulse -> irq_start=1 next cycle; ack 1 cycle -> 6 CALC cycles, count 0..5 -> irq_done=1, count=5; ack -> IDLE, busy=0, count stays 5.
- Auto-reload, ch1, limit=2, ack tied high: sequence IRQ_START(1), CALC(3), IRQ_DONE(1), then CALC(3), IRQ_DONE(1) repeating; irq_start asserts only once.
- limit=0 and limit=all-ones (CNT_W=8): CALC lasts 1 and 256 cycles respectively; count ends at 0 and 255; no wrap.
- Abort mid-CALC on ch2 at count=3 -> next cycle IDLE, count=0, busy=0, no irq_done; ch3 running concurrently is unaffected.
- Masking: ch0 and ch1 both in IRQ_DONE, irq_en=0b0010 -> irq=1; ack ch1 -> irq=0 while irq_done[0] is still 1.
- Async reset asserted mid-CALC, off clock edge -> all outputs 0 immediately; after release a new start gives a normal sequence.
